// File: rtl/peripheral_mpram_pkg.sv
// peripheral_mpram_pkg: shared state encoding and RAM write-enable constants
package peripheral_mpram_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
  localparam logic [1:0] WEN_NONE = 2'b11;
  localparam logic [1:0] WEN_WORD = 2'b00;
  localparam logic [1:0] WEN_HIGH = 2'b01;
  localparam logic [1:0] WEN_LOW  = 2'b10;
endpackage

// File: rtl/peripheral_mpram_bb.sv
// peripheral_mpram_bb: synchronous single-port RAM with low-active byte write enables
module peripheral_mpram_bb #(
  parameter int ADDR_MSB = 6
) (
  input  logic              ram_clk,
  input  logic              ram_cen,
  input  logic [1:0]        ram_wen,
  input  logic [ADDR_MSB:0] ram_addr,
  input  logic [15:0]       ram_din,
  output logic [15:0]       ram_dout
);
  logic [15:0] mem [2**(ADDR_MSB+1)];
  always_ff @(posedge ram_clk) begin
    if (!ram_cen) begin
      if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      if (!ram_wen[0]) mem[ram_addr][7:0] <= ram_din[7:0];
      ram_dout <= mem[ram_addr];
    end
  end
endmodule

// File: rtl/peripheral_mpram_bridge.sv
// peripheral_mpram_bridge: 3-cycle bus-to-synchronous-RAM bridge with range/byte-enable checking
module peripheral_mpram_bridge
  import peripheral_mpram_pkg::*;
#(
  parameter int ADDR_MSB = 6,
  parameter int MEM_SIZE = 256
) (
  input  logic                ram_clk,
  input  logic                ram_rst_n,
  input  logic                bus_req,
  input  logic                bus_we,
  input  logic [1:0]          bus_be,
  input  logic [ADDR_MSB+1:0] bus_addr,
  input  logic [15:0]         bus_wdata,
  output logic                bus_ready,
  output logic                bus_rvalid,
  output logic                bus_err,
  output logic [15:0]         bus_rdata,
  output logic [ADDR_MSB:0]   ram_addr,
  output logic                ram_cen,
  output logic [1:0]          ram_wen,
  output logic [15:0]         ram_din,
  input  logic [15:0]         ram_dout
);
  localparam int unsigned WORDS = MEM_SIZE / 2;
  state_t              state_q, state_d;
  logic [ADDR_MSB:0]   addr_q, addr_d;
  logic [15:0]         din_q, din_d, rdata_q, rdata_d;
  logic [1:0]          wen_q, wen_d;
  logic                cen_q, cen_d, rvalid_q, rvalid_d, err_q, err_d, we_q, we_d;
  logic [ADDR_MSB:0]   word;
  logic                accept, legal, go, unused_ok;
  assign word      = bus_addr[ADDR_MSB+1:1];
  assign unused_ok = bus_addr[0];
  assign accept    = state_q == IDLE && bus_req;
  assign legal     = 32'(word) < WORDS && !(bus_we && bus_be == 2'b00);
  assign go        = accept && legal;
  always_comb begin
    state_d  = go ? ACCESS : state_q == ACCESS ? CAPTURE : IDLE;
    cen_d    = !go;
    wen_d    = go && bus_we ? ~bus_be : WEN_NONE;
    addr_d   = go ? word : addr_q;
    din_d    = go ? bus_wdata : din_q;
    we_d     = go ? bus_we : we_q;
    rvalid_d = (accept && !legal) || state_q == CAPTURE;
    err_d    = accept && !legal;
    rdata_d  = state_q == CAPTURE && !we_q ? ram_dout : rdata_q;
  end
  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) begin
      state_q  <= IDLE;
      cen_q    <= 1'b1;
      wen_q    <= WEN_NONE;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cen_q    <= cen_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end
  assign bus_ready  = state_q == IDLE;
  assign bus_rvalid = rvalid_q;
  assign bus_err    = err_q;
  assign bus_rdata  = rdata_q;
  assign ram_addr   = addr_q;
  assign ram_cen    = cen_q;
  assign ram_wen    = wen_q;
  assign ram_din    = din_q;
endmodule

// File: tb/tb_peripheral_mpram_bridge.sv
// tb_peripheral_mpram_bridge: directed table-driven check of the bridge against a RAM model
module tb_peripheral_mpram_bridge;
  localparam int AM = 7;
  logic ram_clk = 1'b0, ram_rst_n = 1'b0;
  logic bus_req = 1'b0, bus_we = 1'b0;
  logic [1:0] bus_be = 2'b00;
  logic [AM+1:0] bus_addr = '0;
  logic [15:0] bus_wdata = '0;
  logic bus_ready, bus_rvalid, bus_err, ram_cen;
  logic [15:0] bus_rdata, ram_din, ram_dout;
  logic [AM:0] ram_addr;
  logic [1:0] ram_wen;
  int tests = 0, fails = 0;
  always #5 ram_clk = ~ram_clk;
  peripheral_mpram_bridge #(.ADDR_MSB(AM), .MEM_SIZE(256)) dut (
    .ram_clk(ram_clk), .ram_rst_n(ram_rst_n), .bus_req(bus_req), .bus_we(bus_we),
    .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rvalid(bus_rvalid), .bus_err(bus_err), .bus_rdata(bus_rdata), .ram_addr(ram_addr),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_din(ram_din), .ram_dout(ram_dout));
  peripheral_mpram_bb #(.ADDR_MSB(AM)) mem (
    .ram_clk(ram_clk), .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout));
  typedef struct {
    logic we; logic [1:0] be; logic [AM+1:0] addr; logic [15:0] wdata;
    logic err; logic [1:0] wen; logic [15:0] rdata;
  } vec_t;
  vec_t v [11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge ram_clk);
    #1;
  endtask
  task automatic run(input vec_t x, input string n);
    logic [15:0] old;
    old = bus_rdata;
    bus_req = 1'b1; bus_we = x.we; bus_be = x.be; bus_addr = x.addr; bus_wdata = x.wdata;
    chk({n, "_ready0"}, bus_ready, 1);
    tick();
    bus_req = 1'b0;
    if (x.err) begin
      chk({n, "_rv1"}, {bus_rvalid, bus_err, ram_cen}, 3'b111);
      chk({n, "_rdata"}, bus_rdata, old);
      chk({n, "_ready1"}, bus_ready, 1);
      tick();
    end else begin
      chk({n, "_c1"}, {ram_cen, ram_wen, bus_ready, bus_rvalid}, {1'b0, x.wen, 2'b00});
      chk({n, "_addr"}, ram_addr, 32'(x.addr[AM+1:1]));
      if (x.we) chk({n, "_din"}, ram_din, x.wdata);
      tick();
      chk({n, "_c2"}, {ram_cen, ram_wen, bus_ready, bus_rvalid}, 5'b11100);
      tick();
      chk({n, "_c3"}, {bus_rvalid, bus_err, bus_ready, ram_cen}, 4'b1011);
      chk({n, "_rdata"}, bus_rdata, x.rdata);
      tick();
      chk({n, "_c4"}, bus_rvalid, 0);
    end
  endtask
  initial begin
    logic [11:0] rdy, rv, cl;
    vec_t r;
    v[0]  = '{1'b1, 2'b11, 9'h010, 16'hA5C3, 1'b0, 2'b00, 16'h0000};
    v[1]  = '{1'b0, 2'b11, 9'h010, 16'h0000, 1'b0, 2'b11, 16'hA5C3};
    v[2]  = '{1'b1, 2'b11, 9'h020, 16'h1234, 1'b0, 2'b00, 16'hA5C3};
    v[3]  = '{1'b1, 2'b10, 9'h020, 16'hAB00, 1'b0, 2'b01, 16'hA5C3};
    v[4]  = '{1'b0, 2'b00, 9'h020, 16'h0000, 1'b0, 2'b11, 16'hAB34};
    v[5]  = '{1'b0, 2'b11, 9'h100, 16'h0000, 1'b1, 2'b11, 16'hAB34};
    v[6]  = '{1'b1, 2'b00, 9'h030, 16'hFFFF, 1'b1, 2'b11, 16'hAB34};
    v[7]  = '{1'b1, 2'b11, 9'h0FE, 16'hBEEF, 1'b0, 2'b00, 16'hAB34};
    v[8]  = '{1'b0, 2'b11, 9'h0FE, 16'h0000, 1'b0, 2'b11, 16'hBEEF};
    v[9]  = '{1'b1, 2'b01, 9'h011, 16'h77CD, 1'b0, 2'b10, 16'hBEEF};
    v[10] = '{1'b0, 2'b11, 9'h010, 16'h0000, 1'b0, 2'b11, 16'hA5CD};
    #2;
    chk("reset_vals", {bus_ready, bus_rvalid, bus_err, ram_cen, ram_wen, bus_rdata, ram_din, 8'(ram_addr)},
        {1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 16'h0, 16'h0, 8'h0});
    tick(); tick();
    ram_rst_n = 1'b1;
    tick();
    chk("ready_after_release", bus_ready, 1);
    for (int i = 0; i < 11; i++) run(v[i], $sformatf("v%0d", i));
    bus_req = 1'b1; bus_we = 1'b0; bus_be = 2'b11; bus_addr = 9'h0FE;
    for (int i = 0; i < 12; i++) begin
      rdy[i] = bus_ready; rv[i] = bus_rvalid; cl[i] = !ram_cen;
      tick();
      if (i == 9) bus_req = 1'b0;
    end
    chk("b2b_ready", rdy, 12'b0010_0100_1001);
    chk("b2b_rvalid", rv, 12'b0010_0100_1000);
    chk("b2b_cen", cl, 12'b0100_1001_0010);
    chk("b2b_last_rv", {bus_rvalid, bus_rdata}, {1'b1, 16'hBEEF});
    tick();
    r = '{1'b1, 2'b11, 9'h040, 16'h1357, 1'b0, 2'b00, 16'hBEEF};
    run(r, "wr40");
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 9'h040;
    tick();
    bus_req = 1'b0;
    chk("rst_in_access", ram_cen, 0);
    #1 ram_rst_n = 1'b0;
    #1;
    chk("rst_async", {bus_ready, bus_rvalid, bus_err, ram_cen, ram_wen, bus_rdata, ram_din, 8'(ram_addr)},
        {1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 16'h0, 16'h0, 8'h0});
    rv = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      rv[i] = bus_rvalid;
    end
    ram_rst_n = 1'b1;
    for (int i = 3; i < 6; i++) begin
      tick();
      rv[i] = bus_rvalid;
    end
    chk("rst_no_rvalid", rv, 0);
    chk("rst_ready", bus_ready, 1);
    r = '{1'b0, 2'b11, 9'h040, 16'h0000, 1'b0, 2'b11, 16'h1357};
    run(r, "rd40");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/peripheral_mpram_bridge.md
PERIPHERAL_MPRAM_BRIDGE -- requirements
Module: peripheral_mpram_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_MSB, default 6, meaning MSB of the RAM word address.
REQ-002 The block SHALL have parameter MEM_SIZE, default 256, meaning memory size in bytes.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; the ports SHALL be named ram_clk and ram_rst_n.
REQ-004 Ports SHALL be:
- ram_clk  in  1  clock.
- ram_rst_n  in  1  asynchronous active-low reset.
- bus_req  in  1  request.
- bus_we  in  1  1=write, 0=read.
- bus_be  in  2  byte enables; bit1=high byte.
- bus_addr  in  ADDR_MSB+2  byte address; bit0 ignored.
- bus_wdata  in  16  write data.
- bus_ready  out  1  bridge accepts a request this cycle.
- bus_rvalid  out  1  one-cycle completion strobe.
- bus_err  out  1  error, qualified by bus_rvalid.
- bus_rdata  out  16  read data, held until the next read completes.
- ram_addr  out  ADDR_MSB+1  RAM word address.
- ram_cen  out  1  chip enable, low active.
- ram_wen  out  2  write enables, low active; bit1=high byte.
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM read data, valid the cycle after the access edge.

Function
REQ-005 FSM states SHALL be IDLE, ACCESS and CAPTURE; bus_ready SHALL be 1 only in IDLE.
REQ-006 A request SHALL be accepted on a rising edge with state IDLE and bus_req=1 (cycle 0).
REQ-007 A request SHALL be legal when word address bus_addr[ADDR_MSB+1:1] < MEM_SIZE/2 and, if bus_we=1, bus_be != 00.
REQ-008 For a legal request, the accept edge SHALL:
- register ram_addr=bus_addr[ADDR_MSB+1:1], ram_din=bus_wdata;
- register ram_wen=~bus_be for a write, 11 for a read;
- drive ram_cen=0;
- enter ACCESS (cycle 1).
REQ-009 On leaving ACCESS, ram_cen SHALL return to 1, ram_wen to 11, and the state SHALL enter CAPTURE (cycle 2); ram_cen SHALL be low for exactly one cycle per access.
REQ-010 On leaving CAPTURE, the block SHALL load bus_rdata from ram_dout (reads only), pulse bus_rvalid=1 with bus_err=0 in cycle 3, and return to IDLE.
REQ-011 Latency from accept edge to rvalid SHALL be 3 cycles; a request presented in cycle 3 SHALL be accepted, giving one transaction per 3 cycles.
REQ-012 For an illegal request, the block SHALL:
- leave ram_cen at 1;
- pulse bus_rvalid=1 and bus_err=1 in cycle 1;
- keep state IDLE;
- leave bus_rdata unchanged.
REQ-013 Writes SHALL leave bus_rdata unchanged; bus_rdata SHALL always present the full 16-bit word regardless of bus_be.
REQ-014 bus_req while not in IDLE SHALL be ignored, and the requester SHALL hold it until bus_ready=1.
REQ-015 Top address MEM_SIZE/2-1 SHALL be legal; the address SHALL NOT wrap to 0.

Reset
REQ-016 Assertion of ram_rst_n=0 SHALL immediately force:
- state IDLE, ram_cen=1, ram_wen=11;
- ram_addr=0, ram_din=0;
- bus_rvalid=0, bus_err=0, bus_rdata=0.
REQ-017 Reset asserted mid-transaction SHALL abort it with no rvalid; an access edge already taken SHALL NOT be repeated.
REQ-018 bus_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-019 Shared package peripheral_mpram_pkg SHALL hold the state enum and the constants WEN_NONE=11, WEN_WORD=00, WEN_HIGH=01 and WEN_LOW=10.
REQ-020 The block SHALL have no sub-module; the bench SHALL connect it to memory model peripheral_mpram_bb downstream.

Verification
REQ-021 Write 0xA5C3 to byte address 0x10 with be=11, then read 0x10 -> ram_cen low one cycle with ram_addr=0x08 and ram_wen=00; read rvalid at cycle 3 with rdata=0xA5C3 and err=0.
REQ-022 Word 0x1234 at 0x20, write 0xAB00 with be=10, then read -> ram_wen=01 during the write; read returns 0xAB34.
REQ-023 Read of 0x100 (word 0x80 >= 128) and write with be=00 -> rvalid+err in cycle 1; ram_cen stays 1; rdata unchanged.
REQ-024 bus_req held high for 4 transactions -> accepts at cycles 0, 3, 6 and 9; ready low in ACCESS/CAPTURE; top address 0xFE is legal.
REQ-025 Reset asserted during ACCESS -> outputs take reset values asynchronously; no rvalid; a read after release returns the value last written.
